// File: rtl/seq_divider4.sv
// rtl/seq_divider4.sv - multi-cycle unsigned restoring divider with start/busy/done handshake
// One shift/trial-subtract per clock; results and done are registered one cycle after the DONE state.
module seq_divider4 #(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_dq, r_dv, r_rem;
  logic [WIDTH-1:0] r_quo, r_remo;
  logic [CW-1:0]    r_cnt;
  logic             r_zero, r_done, r_dbz;
  logic             w_accept, w_borrow;
  logic [WIDTH-1:0] w_shift;
  logic [WIDTH:0]   w_trial;

  // r_done keeps the block busy for its pulse cycle, so start is only taken once it drops.
  assign w_accept = (r_state == S_IDLE) && start && !r_done;

  always_comb begin
    w_shift  = {r_rem[WIDTH-2:0], r_dq[WIDTH-1]};
    w_trial  = {1'b0, w_shift} - {1'b0, r_dv};
    w_borrow = w_trial[WIDTH];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (divisor == '0) ? S_DONE : S_RUN;
      S_RUN:  if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dq    <= '0;
      r_dv    <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_done  <= 1'b0;
      r_quo   <= '0;
      r_remo  <= '0;
      r_dbz   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dq   <= dividend;
            r_dv   <= divisor;
            r_rem  <= '0;
            r_cnt  <= CNT_INIT;
            r_zero <= (divisor == '0);
            r_dbz  <= 1'b0;
          end
        end
        S_RUN: begin
          r_dq  <= {r_dq[WIDTH-2:0], ~w_borrow};
          r_rem <= w_borrow ? w_shift : w_trial[WIDTH-1:0];
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_DONE: begin
          // On divide-by-zero r_dq was never shifted, so it still holds the dividend.
          r_quo  <= r_zero ? '1 : r_dq;
          r_remo <= r_zero ? r_dq : r_rem;
          r_dbz  <= r_zero;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE) | r_done;
  assign done        = r_done;
  assign quotient    = r_quo;
  assign remainder   = r_remo;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider4.sv
// tb/tb_seq_divider4.sv - directed and exhaustive self-checking bench for seq_divider4
module tb_seq_divider4;

  logic       CLOCK_50 = 1'b0;
  logic       reset, start;
  logic [3:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [3:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  seq_divider4 #(.WIDTH(4)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents operands for one edge, then scrambles them; returns at the first negedge after acceptance.
  task automatic launch(input logic [3:0] a, input logic [3:0] b);
    @(negedge CLOCK_50);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge CLOCK_50);
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    check("busy_after_accept", {31'b0, busy}, 32'd1);
  endtask

  task automatic finish(input string tag, input int lat0, input int exp_lat,
                        input logic [3:0] eq, input logic [3:0] er, input logic ez);
    int lat;
    lat = lat0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge CLOCK_50);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_q"}, {28'b0, quotient}, {28'b0, eq});
    check({tag, "_r"}, {28'b0, remainder}, {28'b0, er});
    check({tag, "_dbz"}, {31'b0, div_by_zero}, {31'b0, ez});
    check({tag, "_busy_with_done"}, {31'b0, busy}, 32'd1);
    @(negedge CLOCK_50);
    check({tag, "_done_one_cycle"}, {31'b0, done}, 32'd0);
    check({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
    check({tag, "_q_held"}, {28'b0, quotient}, {28'b0, eq});
  endtask

  initial begin
    logic [3:0] eq, er;
    int         seen_done;

    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge CLOCK_50);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_q", {28'b0, quotient}, 32'd0);
    check("rst_r", {28'b0, remainder}, 32'd0);
    check("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    reset = 1'b0;

    launch(4'd13, 4'd3);  finish("d13_3", 0, 5, 4'd4, 4'd1, 1'b0);
    launch(4'd15, 4'd1);  finish("d15_1", 0, 5, 4'd15, 4'd0, 1'b0);
    launch(4'd15, 4'd15); finish("d15_15", 0, 5, 4'd1, 4'd0, 1'b0);
    launch(4'd3, 4'd9);   finish("d3_9", 0, 5, 4'd0, 4'd3, 1'b0);

    launch(4'd7, 4'd0);   finish("d7_0", 0, 1, 4'd15, 4'd7, 1'b1);
    repeat (2) @(negedge CLOCK_50);
    check("dbz_held", {31'b0, div_by_zero}, 32'd1);
    launch(4'd6, 4'd2);
    check("dbz_cleared_on_start", {31'b0, div_by_zero}, 32'd0);
    finish("d6_2", 0, 5, 4'd3, 4'd0, 1'b0);

    // A start pulse during RUN must be dropped, not queued.
    launch(4'd9, 4'd2);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    start = 1'b1; dividend = 4'd1; divisor = 4'd1;
    @(negedge CLOCK_50);
    start = 1'b0;
    finish("d9_2_ignore", 3, 5, 4'd4, 4'd1, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    check("no_queued_start", {31'b0, busy}, 32'd0);

    // Continuous start: restart is accepted on the edge closing the first IDLE cycle.
    @(negedge CLOCK_50);
    start = 1'b1; dividend = 4'd8; divisor = 4'd2;
    @(negedge CLOCK_50);
    seen_done = 0;
    while (done !== 1'b1 && seen_done < 20) begin
      @(negedge CLOCK_50);
      seen_done++;
    end
    check("held_first_q", {28'b0, quotient}, 32'd4);
    @(negedge CLOCK_50);
    check("held_gap_busy", {31'b0, busy}, 32'd0);
    @(negedge CLOCK_50);
    check("held_restart_busy", {31'b0, busy}, 32'd1);
    start = 1'b0;
    finish("held_second", 0, 5, 4'd4, 4'd0, 1'b0);

    // Reset in the third RUN cycle aborts and clears results.
    launch(4'd13, 4'd3);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_q", {28'b0, quotient}, 32'd0);
    check("abort_r", {28'b0, remainder}, 32'd0);
    seen_done = 0;
    repeat (8) begin
      @(negedge CLOCK_50);
      if (done === 1'b1) seen_done = 1;
    end
    check("abort_no_done", seen_done, 32'd0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        launch(4'(a), 4'(b));
        finish($sformatf("ex_%0d_%0d", a, b), 0, (b == 0) ? 1 : 5, eq, er, (b == 0));
        if (b != 0) begin
          check($sformatf("inv_%0d_%0d", a, b),
                {31'b0, (32'(quotient) * b + 32'(remainder) == a) && (32'(remainder) < b)}, 32'd1);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
